// File: rtl/bsg_upstream_pkg.sv
// Shared helpers for the upstream output serializer.
//   beat_idx_w : width of a beat index register for a given beat count
//   slice_off  : bit offset of (channel, beat) inside a core word
//   WORDS_SENT_W : width of the wrapping transmitted-word counter
package bsg_upstream_pkg;

  localparam int WORDS_SENT_W = 16;

  function automatic int beat_idx_w(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  // A channel's beats are contiguous in the core word, so channel c owns
  // bits [c*beats*ch_w +: beats*ch_w] and beat b is the b-th slice of that.
  function automatic int slice_off(input int c, input int b, input int beats,
                                   input int ch_w);
    return (c * beats + b) * ch_w;
  endfunction

endpackage

// File: rtl/bsg_upstream_word_fifo.sv
// Word FIFO for the upstream serializer.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write data_i when not full (push while full is dropped)
//   data_i     : W-bit word
//   pop_i      : remove head when not empty
//   head_o     : current head word, combinational from storage
//   empty_o    : no words held
//   full_o     : DEPTH words held
module bsg_upstream_word_fifo
  import bsg_upstream_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);  // DEPTH is a power of two: natural wrap
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never presented while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bsg_upstream_out_serializer.sv
// Upstream off-chip output serializer: buffers core words in a FIFO and sends
// each as BEATS beats over CHANNELS parallel CH_W-bit channels.
//   clk, rst        : clock, synchronous active-high reset
//   core_valid_in   : core word valid; core_data_in : core word (W bits)
//   core_ready_out  : FIFO not full
//   io_ready        : link accepts current beat
//   io_valid_out    : beat valid (FIFO non-empty)
//   io_data_out     : beat data, channel c at [c*CH_W +: CH_W]; 0 when idle
//   io_last_out     : current beat is the last of its word
//   words_sent      : wrapping count of fully transmitted words
module bsg_upstream_out_serializer
  import bsg_upstream_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int CH_W     = 8,
  parameter  int BEATS    = 2,
  parameter  int DEPTH    = 4,
  localparam int W        = CHANNELS * CH_W * BEATS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_valid_in,
  input  logic [W-1:0]             core_data_in,
  output logic                     core_ready_out,
  input  logic                     io_ready,
  output logic                     io_valid_out,
  output logic [CHANNELS*CH_W-1:0] io_data_out,
  output logic                     io_last_out,
  output logic [WORDS_SENT_W-1:0]  words_sent
);

  localparam int BW = beat_idx_w(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [W-1:0]            head;
  logic                    empty, full;
  logic                    xfer, word_done;
  logic [BW-1:0]           cnt_q, cnt_d;
  logic [WORDS_SENT_W-1:0] words_sent_q, words_sent_d;

  // Ready comes from registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  bsg_upstream_word_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (core_valid_in),
    .data_i  (core_data_in),
    .pop_i   (word_done),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full)
  );

  assign core_ready_out = !full;
  assign io_valid_out   = !empty;
  assign io_last_out    = io_valid_out && (cnt_q == LAST_BEAT);
  assign xfer           = io_valid_out && io_ready;
  assign word_done      = xfer && (cnt_q == LAST_BEAT);
  assign words_sent     = words_sent_q;

  always_comb begin
    io_data_out = '0;
    if (io_valid_out) begin
      for (int c = 0; c < CHANNELS; c++) begin
        io_data_out[c*CH_W +: CH_W] = head[slice_off(c, int'(cnt_q), BEATS, CH_W) +: CH_W];
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    words_sent_d = words_sent_q;
    if (xfer) begin
      if (word_done) begin
        cnt_d        = '0;
        words_sent_d = words_sent_q + WORDS_SENT_W'(1);
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      words_sent_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      words_sent_q <= words_sent_d;
    end
  end

endmodule
